// File: rtl/mux_4_1_pkg.sv
// Shared select-code definitions for the 4:1 selector.
package mux_4_1_pkg;

  typedef enum logic [1:0] {
    SEL_D0 = 2'b00,
    SEL_D1 = 2'b01,
    SEL_D2 = 2'b10,
    SEL_D3 = 2'b11
  } sel_e;

  function automatic sel_e sel_code(input logic s1, input logic s0);
    return sel_e'({s1, s0});
  endfunction

endpackage

// File: rtl/mux_4_1_mux2.sv
// WIDTH-parameterized 2:1 selector; an unknown sel merges a/b bitwise (X where they differ).
module mux2_1 #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux_4_1.sv
// Four-way selector built from a tree of 2:1 selectors, with a registered copy of the result.
module mux_4_1
  import mux_4_1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic             s0,
  input  logic             s1,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q
);

  sel_e             sel;
  logic [WIDTH-1:0] low_pair;
  logic [WIDTH-1:0] high_pair;

  assign sel = sel_code(s1, s0);

  // First level picks within each pair on the LSB; second level picks the pair on the MSB.
  mux2_1 #(.WIDTH(WIDTH)) u_low (
    .a   (d0),
    .b   (d1),
    .sel (sel[0]),
    .y   (low_pair)
  );

  mux2_1 #(.WIDTH(WIDTH)) u_high (
    .a   (d2),
    .b   (d3),
    .sel (sel[0]),
    .y   (high_pair)
  );

  mux2_1 #(.WIDTH(WIDTH)) u_final (
    .a   (low_pair),
    .b   (high_pair),
    .sel (sel[1]),
    .y   (out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out;
    end
  end

endmodule

// File: tb/tb_mux_4_1.sv
// Self-checking bench for mux_4_1: directed vector table, reset sequences, randomized reference checks.
module tb_mux_4_1;

  logic       clk;
  logic       rst_n;
  logic [7:0] d0, d1, d2, d3;
  logic       s0, s1;
  logic [0:0] out1, out_q1;
  logic [7:0] out8, out_q8;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] d0, d1, d2, d3;
    logic       s1, s0;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[10];

  mux_4_1 #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .d0    (d0[0:0]),
    .d1    (d1[0:0]),
    .d2    (d2[0:0]),
    .d3    (d3[0:0]),
    .s0    (s0),
    .s1    (s1),
    .out   (out1),
    .out_q (out_q1)
  );

  mux_4_1 #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .d0    (d0),
    .d1    (d1),
    .d2    (d2),
    .d3    (d3),
    .s0    (s0),
    .s1    (s1),
    .out   (out8),
    .out_q (out_q8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the select code is a plain array index into the four sources.
  function automatic logic [7:0] model(input logic [7:0] a, b, c, d, input logic hi, lo);
    logic [7:0] src[4];
    src[0] = a; src[1] = b; src[2] = c; src[3] = d;
    return src[2 * int'(hi) + int'(lo)];
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  initial begin
    logic [7:0] exp;

    vecs[0] = '{8'h01, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 8'h01};
    vecs[1] = '{8'h01, 8'h00, 8'h00, 8'h01, 1'b1, 1'b0, 8'h00};
    vecs[2] = '{8'h01, 8'h00, 8'h00, 8'h01, 1'b0, 1'b1, 8'h00};
    vecs[3] = '{8'h01, 8'h00, 8'h00, 8'h01, 1'b1, 1'b1, 8'h01};
    vecs[4] = '{8'h00, 8'h01, 8'h00, 8'h00, 1'b0, 1'b1, 8'h01};
    vecs[5] = '{8'h00, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00};
    vecs[6] = '{8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 1'b0, 8'h11};
    vecs[7] = '{8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 1'b1, 8'h22};
    vecs[8] = '{8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 1'b0, 8'h33};
    vecs[9] = '{8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 1'b1, 8'h44};

    rst_n = 1'b1;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    s0 = 1'b0; s1 = 1'b0;
    #1 rst_n = 1'b0;

    // Directed table, applied while reset is held: out must work, out_q must stay 0.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      d0 = vecs[i].d0; d1 = vecs[i].d1; d2 = vecs[i].d2; d3 = vecs[i].d3;
      s1 = vecs[i].s1; s0 = vecs[i].s0;
      #2;
      check($sformatf("vec%0d_out8", i), out8, vecs[i].exp);
      check($sformatf("vec%0d_out1", i), {7'b0, out1}, {7'b0, vecs[i].exp[0]});
      @(posedge clk); #1;
      check($sformatf("vec%0d_outq_in_reset", i), out_q8, 8'h00);
    end

    // Reset release: first capture on first rising edge after rst_n rises.
    @(negedge clk);
    d0 = 8'h01; d1 = 8'h00; d2 = 8'h00; d3 = 8'h00; s0 = 1'b0; s1 = 1'b0;
    #2;
    check("rst_out1", {7'b0, out1}, 8'h01);
    check("rst_outq1", {7'b0, out_q1}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_no_edge_outq8", out_q8, 8'h00);
    @(posedge clk); #1;
    check("release_outq1", {7'b0, out_q1}, 8'h01);
    check("release_outq8", out_q8, 8'h01);

    // Randomized: out against the model immediately, out_q one edge later.
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      d0 = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom); d3 = 8'($urandom);
      s0 = 1'($urandom); s1 = 1'($urandom);
      exp = model(d0, d1, d2, d3, s1, s0);
      #1;
      check("rand_out8", out8, exp);
      check("rand_out1", {7'b0, out1}, {7'b0, exp[0]});
      @(posedge clk); #1;
      check("rand_outq8", out_q8, exp);
      check("rand_outq1", {7'b0, out_q1}, {7'b0, exp[0]});
    end

    // Mid-operation reset between edges: out_q clears immediately, out unaffected.
    @(negedge clk);
    d0 = 8'hFF; d1 = 8'h00; d2 = 8'h00; d3 = 8'h00; s0 = 1'b0; s1 = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_outq8", out_q8, 8'hFF);
    check("pre_reset_outq1", {7'b0, out_q1}, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    check("async_clear_outq8", out_q8, 8'h00);
    check("async_clear_outq1", {7'b0, out_q1}, 8'h00);
    check("async_out8_unaffected", out8, 8'hFF);
    @(posedge clk); #1;
    check("hold_outq8", out_q8, 8'h00);
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
